fetch_unit: RTL and testbench

- Instruction fetch stage of the RISC-V core, ending in the IF/ID pipeline register.
- Holds the PC and issues single-outstanding requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Presents instr_d/pc_d/pcplus4_d to decode. instr_d[31:7] drives the immediate extender; pc_d feeds branch-target computation.
- Accepts taken-branch/jump redirects and stall/flush from hazard control.

---
 rtl/core_pkg.sv | 19 +
 rtl/ifid_reg.sv | 68 ++++++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: data width, fetch FSM states and the canonical NOP.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR_C = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  // Instruction addresses are word aligned; low two bits are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// Pipeline register between fetch and decode: load beats flush, flush beats stall,
// and an idle cycle with room to accept becomes a bubble.
module ifid_reg
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pcplus4_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pcplus4_o,
  output logic            valid_o
);

  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pcplus4_q, pcplus4_d;
  logic            valid_q, valid_d;

  // Next-state selection with load > flush > stall > bubble priority.
  always_comb begin
    instr_d   = instr_q;
    pc_d      = pc_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (load_i) begin
      instr_d   = instr_i;
      pc_d      = pc_i;
      pcplus4_d = pcplus4_i;
      valid_d   = 1'b1;
    end else if (flush_i) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (stall_i) begin
      valid_d = valid_q;
    end else begin
      valid_d = 1'b0;
    end
  end

  // Register state with asynchronous reset to an invalid NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= NOP_INSTR;
      pc_q      <= 32'h0000_0000;
      pcplus4_q <= 32'h0000_0000;
      valid_q   <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  assign instr_o   = instr_q;
  assign pc_o      = pc_q;
  assign pcplus4_o = pcplus4_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem request FSM, one-entry skid
// buffer for responses that arrive while decode is stalled, and the IF/ID register.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            pc_src_i,
  input  logic [XLEN-1:0] pc_target_i,
  input  logic            stall_d,
  input  logic            flush_d,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus4_d,
  output logic            valid_d
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            discard_q, discard_d;

  logic            can_accept;
  logic            ifid_load;
  logic [XLEN-1:0] ifid_instr;
  logic [XLEN-1:0] ifid_pc;

  assign can_accept     = !stall_d || !valid_d;
  assign imem_req_valid = (state_q == S_REQ);
  assign imem_addr      = pc_f_q;

  // Fetch FSM: request issue, response routing, skid drain and redirect handling.
  always_comb begin
    state_d      = state_q;
    pc_seq       = pc_f_q;
    req_pc_d     = req_pc_q;
    discard_d    = discard_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    ifid_load    = 1'b0;
    ifid_instr   = imem_rsp_data;
    ifid_pc      = req_pc_q;
    case (state_q)
      S_REQ: begin
        if (imem_req_ready) begin
          req_pc_d  = pc_f_q;
          pc_seq    = pc_f_q + 32'd4;
          // A redirect in the accept cycle makes this request stale.
          discard_d = pc_src_i;
          state_d   = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          discard_d = 1'b0;
          if (discard_q || pc_src_i) begin
            state_d = S_REQ;
          end else if (can_accept) begin
            ifid_load = 1'b1;
            state_d   = S_REQ;
          end else begin
            skid_instr_d = imem_rsp_data;
            skid_pc_d    = req_pc_q;
            state_d      = S_HOLD;
          end
        end else if (pc_src_i) begin
          discard_d = 1'b1;
        end else begin
          discard_d = discard_q;
        end
      end
      S_HOLD: begin
        if (pc_src_i) begin
          state_d = S_REQ;
        end else if (!stall_d) begin
          ifid_load  = 1'b1;
          ifid_instr = skid_instr_q;
          ifid_pc    = skid_pc_q;
          state_d    = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d   = S_REQ;
        discard_d = 1'b0;
      end
    endcase
    pc_f_d = pc_src_i ? align_word(pc_target_i) : pc_seq;
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_REQ;
      pc_f_q       <= RESET_PC;
      req_pc_q     <= 32'h0000_0000;
      discard_q    <= 1'b0;
      skid_instr_q <= 32'h0000_0000;
      skid_pc_q    <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      req_pc_q     <= req_pc_d;
      discard_q    <= discard_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid (
    .clk      (clk),
    .rst_n    (reset_n),
    .load_i   (ifid_load),
    .stall_i  (stall_d),
    .flush_i  (flush_d || pc_src_i),
    .instr_i  (ifid_instr),
    .pc_i     (ifid_pc),
    .pcplus4_i(ifid_pc + 32'd4),
    .instr_o  (instr_d),
    .pc_o     (pc_d),
    .pcplus4_o(pcplus4_d),
    .valid_o  (valid_d)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked against an in-order fetch-stream model with a behavioural memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        pc_src_i;
  logic [31:0] pc_target_i;
  logic        stall_d;
  logic        flush_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;

  int n_tests = 0;
  int n_fail  = 0;

  bit          pending = 1'b0;
  logic [31:0] pend_addr;
  int          cnt;
  int          lat_min = 1;
  int          lat_max = 1;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .pc_src_i      (pc_src_i),
    .pc_target_i   (pc_target_i),
    .stall_d       (stall_d),
    .flush_d       (flush_d),
    .instr_d       (instr_d),
    .pc_d          (pc_d),
    .pcplus4_d     (pcplus4_d),
    .valid_d       (valid_d)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0050_0093;
    else if (a == 32'h0000_0004) return 32'h0010_0113;
    else return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // One clock of the memory model: accept, count latency, return one response.
  task automatic step();
    bit acc, fire;
    logic [31:0] a;
    acc  = imem_req_valid && imem_req_ready;
    fire = imem_rsp_valid;
    a    = imem_addr;
    @(posedge clk);
    #1;
    if (fire) pending = 1'b0;
    if (acc) begin
      pending   = 1'b1;
      pend_addr = a;
      cnt       = $urandom_range(lat_max, lat_min);
    end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (pending && cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
      end
    end
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = valid_d;
    for (int i = 0; i < max && !ok; i++) begin
      step();
      ok = valid_d;
    end
  endtask

  task automatic wait_req(input int max, output bit ok);
    ok = imem_req_valid;
    for (int i = 0; i < max && !ok; i++) begin
      step();
      ok = imem_req_valid;
    end
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    pc_src_i       = 1'b0;
    pc_target_i    = 32'h0;
    stall_d        = 1'b0;
    flush_d        = 1'b0;
    pending        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({valid_d, instr_d, pc_d, pcplus4_d} !== {1'b0, 32'h0000_0013, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_ifid got v=%b i=%h pc=%h p4=%h", valid_d, instr_d, pc_d, pcplus4_d);
    end
    n_tests++;
    if ({imem_req_valid, imem_addr} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_req got v=%b a=%h exp v=1 a=0", imem_req_valid, imem_addr);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1;
    n_tests++;
    if ({imem_req_valid, imem_addr} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL basic_addr0 got v=%b a=%h exp 1/0", imem_req_valid, imem_addr);
    end
    step();
    step();
    n_tests++;
    if ({valid_d, instr_d, pc_d, pcplus4_d} !== {1'b1, 32'h0050_0093, 32'h0, 32'h4}) begin
      n_fail++;
      $display("FAIL basic_first got v=%b i=%h pc=%h p4=%h exp 1 00500093 0 4", valid_d, instr_d, pc_d, pcplus4_d);
    end
    n_tests++;
    if ({imem_req_valid, imem_addr} !== {1'b1, 32'h4}) begin
      n_fail++; $display("FAIL basic_addr4 got v=%b a=%h exp 1/4", imem_req_valid, imem_addr);
    end
    step();
    n_tests++;
    if (valid_d !== 1'b0) begin
      n_fail++; $display("FAIL basic_bubble got valid=%b exp 0", valid_d);
    end
    step();
    n_tests++;
    if ({valid_d, instr_d, pc_d} !== {1'b1, 32'h0010_0113, 32'h4}) begin
      n_fail++; $display("FAIL basic_second got v=%b i=%h pc=%h exp 1 00100113 4", valid_d, instr_d, pc_d);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    lat_min = 3; lat_max = 3;
    n_tests++;
    if ({imem_req_valid, imem_addr} !== {1'b1, 32'h8}) begin
      n_fail++; $display("FAIL rw_addr8 got v=%b a=%h exp 1/8", imem_req_valid, imem_addr);
    end
    step();
    pc_src_i = 1'b1; pc_target_i = 32'h0000_0100;
    step();
    pc_src_i = 1'b0; pc_target_i = $urandom;
    for (int i = 0; i < 10 && !imem_req_valid; i++) begin
      n_tests++;
      if (valid_d !== 1'b0) begin
        n_fail++; $display("FAIL rw_drop got valid=%b pc=%h exp valid 0", valid_d, pc_d);
      end
      step();
    end
    n_tests++;
    if ({imem_req_valid, imem_addr} !== {1'b1, 32'h100}) begin
      n_fail++; $display("FAIL rw_addr100 got v=%b a=%h exp 1/100", imem_req_valid, imem_addr);
    end
    lat_min = 1; lat_max = 1;
    wait_valid(10, ok);
    n_tests++;
    if (!ok || pc_d !== 32'h100 || instr_d !== mem_word(32'h100)) begin
      n_fail++; $display("FAIL rw_deliver got ok=%b pc=%h i=%h exp pc 100", ok, pc_d, instr_d);
    end
  endtask

  task automatic test_redirect_accept();
    bit ok;
    imem_req_ready = 1'b0;
    pc_src_i = 1'b1; pc_target_i = 32'h0000_0020;
    step();
    pc_src_i = 1'b0;
    wait_req(10, ok);
    n_tests++;
    if (!ok || imem_addr !== 32'h20) begin
      n_fail++; $display("FAIL ra_addr20 got ok=%b a=%h exp 20", ok, imem_addr);
    end
    imem_req_ready = 1'b1;
    pc_src_i = 1'b1; pc_target_i = 32'h0000_0043;
    step();
    pc_src_i = 1'b0;
    for (int i = 0; i < 10 && !imem_req_valid; i++) begin
      n_tests++;
      if (valid_d !== 1'b0) begin
        n_fail++; $display("FAIL ra_drop got valid=%b pc=%h exp valid 0", valid_d, pc_d);
      end
      step();
    end
    n_tests++;
    if ({imem_req_valid, imem_addr} !== {1'b1, 32'h40}) begin
      n_fail++; $display("FAIL ra_addr40 got v=%b a=%h exp 1/40", imem_req_valid, imem_addr);
    end
    wait_valid(10, ok);
    n_tests++;
    if (!ok || pc_d !== 32'h40 || instr_d !== mem_word(32'h40)) begin
      n_fail++; $display("FAIL ra_deliver got ok=%b pc=%h i=%h exp pc 40", ok, pc_d, instr_d);
    end
  endtask

  task automatic test_stall_skid();
    logic [31:0] h_instr, h_pc;
    bit ok;
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1;
    wait_valid(10, ok);
    h_instr = instr_d; h_pc = pc_d;
    stall_d = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_tests++;
      if (!ok || {valid_d, instr_d, pc_d} !== {1'b1, h_instr, h_pc}) begin
        n_fail++; $display("FAIL stall_hold%0d got v=%b i=%h pc=%h exp pc %h", k, valid_d, instr_d, pc_d, h_pc);
      end
      n_tests++;
      if (imem_req_valid !== 1'b0) begin
        n_fail++; $display("FAIL stall_noreq%0d got req_valid=%b exp 0", k, imem_req_valid);
      end
    end
    stall_d = 1'b0;
    step();
    n_tests++;
    if ({valid_d, pc_d, instr_d, pcplus4_d} !== {1'b1, h_pc + 32'd4, mem_word(h_pc + 32'd4), h_pc + 32'd8}) begin
      n_fail++; $display("FAIL stall_skid got v=%b pc=%h i=%h exp pc %h", valid_d, pc_d, instr_d, h_pc + 32'd4);
    end
    n_tests++;
    if ({imem_req_valid, imem_addr} !== {1'b1, h_pc + 32'd8}) begin
      n_fail++; $display("FAIL stall_next got v=%b a=%h exp %h", imem_req_valid, imem_addr, h_pc + 32'd8);
    end
  endtask

  task automatic test_flush();
    logic [31:0] a;
    a = imem_addr;
    step();
    flush_d = 1'b1;
    step();
    n_tests++;
    if ({valid_d, pc_d, instr_d} !== {1'b1, a, mem_word(a)}) begin
      n_fail++; $display("FAIL flush_load got v=%b pc=%h i=%h exp 1 %h", valid_d, pc_d, instr_d, a);
    end
    stall_d = 1'b1;
    step();
    n_tests++;
    if ({valid_d, instr_d} !== {1'b0, 32'h0000_0013}) begin
      n_fail++; $display("FAIL flush_only got v=%b i=%h exp 0 00000013", valid_d, instr_d);
    end
    flush_d = 1'b0;
    stall_d = 1'b0;
  endtask

  task automatic test_wrap_reset();
    bit ok;
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b1;
    pc_src_i = 1'b1; pc_target_i = 32'hFFFF_FFFC;
    step();
    pc_src_i = 1'b0;
    wait_valid(20, ok);
    n_tests++;
    if (!ok || {pc_d, pcplus4_d, instr_d} !== {32'hFFFF_FFFC, 32'h0, mem_word(32'hFFFF_FFFC)}) begin
      n_fail++; $display("FAIL wrap_deliver got ok=%b pc=%h p4=%h exp fffffffc 0", ok, pc_d, pcplus4_d);
    end
    n_tests++;
    if ({imem_req_valid, imem_addr} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL wrap_addr got v=%b a=%h exp 1/0", imem_req_valid, imem_addr);
    end
    step();
    #1;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({valid_d, instr_d, pc_d, pcplus4_d, imem_req_valid, imem_addr} !==
        {1'b0, 32'h0000_0013, 32'h0, 32'h0, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL async_reset got v=%b i=%h pc=%h p4=%h rv=%b a=%h", valid_d, instr_d, pc_d, pcplus4_d, imem_req_valid, imem_addr);
    end
    pending = 1'b0;
    imem_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_valid(10, ok);
    n_tests++;
    if (!ok || {pc_d, instr_d} !== {32'h0, 32'h0050_0093}) begin
      n_fail++; $display("FAIL post_reset got ok=%b pc=%h i=%h exp 0 00500093", ok, pc_d, instr_d);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, target, p_instr, p_pc, p_addr;
    bit redir, p_stall, p_valid, p_req, p_ready;
    int deliveries;
    exp_pc = 32'h0; deliveries = 0;
    lat_min = 1; lat_max = 3;
    for (int it = 0; it < 800; it++) begin
      redir   = (it == 0) || ($urandom_range(19, 0) == 0);
      target  = $urandom;
      stall_d = ($urandom_range(9, 0) < 3);
      imem_req_ready = $urandom_range(1, 0);
      pc_src_i    = redir;
      pc_target_i = target;
      p_stall = stall_d; p_valid = valid_d; p_instr = instr_d; p_pc = pc_d;
      p_req = imem_req_valid; p_ready = imem_req_ready; p_addr = imem_addr;
      step();
      pc_src_i = 1'b0;
      if (redir) begin
        exp_pc = target & 32'hFFFF_FFFC;
        n_tests++;
        if (valid_d !== 1'b0) begin
          n_fail++; $display("FAIL rnd_redirect it=%0d got valid=%b exp 0", it, valid_d);
        end
      end else if (p_stall && p_valid) begin
        n_tests++;
        if ({valid_d, instr_d, pc_d} !== {1'b1, p_instr, p_pc}) begin
          n_fail++; $display("FAIL rnd_stall it=%0d got v=%b pc=%h exp pc %h", it, valid_d, pc_d, p_pc);
        end
      end else if (valid_d) begin
        n_tests++;
        if ({pc_d, instr_d, pcplus4_d} !== {exp_pc, mem_word(exp_pc), exp_pc + 32'd4}) begin
          n_fail++; $display("FAIL rnd_stream it=%0d got pc=%h i=%h exp pc %h", it, pc_d, instr_d, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end
      if (!redir && p_req && !p_ready) begin
        n_tests++;
        if ({imem_req_valid, imem_addr} !== {1'b1, p_addr}) begin
          n_fail++; $display("FAIL rnd_addr_stable it=%0d got v=%b a=%h exp %h", it, imem_req_valid, imem_addr, p_addr);
        end
      end
      if (imem_req_valid) begin
        n_tests++;
        if (imem_addr[1:0] !== 2'b00) begin
          n_fail++; $display("FAIL rnd_align it=%0d got a=%h", it, imem_addr);
        end
      end
    end
    stall_d = 1'b0;
    n_tests++;
    if (deliveries < 30) begin
      n_fail++; $display("FAIL rnd_progress got %0d deliveries exp >= 30", deliveries);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_redirect_wait();
    test_redirect_accept();
    test_stall_skid();
    test_flush();
    test_wrap_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
